mem_loader_responder: RTL and testbench
=======================================

MEM_LOADER_RESPONDER -- requirements
Module: mem_loader_responder

Interface
REQ-001 Parameter: RST_HOLD, default 4, number of cycles cpu_reset stays asserted after a load or reset completes (range 1..255).
REQ-002 Parameter: AW, default 16, address width; memory depth is 2^AW bytes.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low block reset.
REQ-005 Port: ab  input  AW  CPU address bus.
REQ-006 Port: do  input  8  CPU write data.
REQ-007 Port: we  input  1  CPU write enable, active-high.
REQ-008 Port: di  output  8  read data to CPU.
REQ-009 Port: cpu_reset  output  1  active-high reset driven to the 6502 core.
REQ-010 Port: ld_start  input  1  one-cycle pulse that begins a program load.
REQ-011 Port: ld_data  input  8  loader byte stream.
REQ-012 Port: ld_valid  input  1  ld_data is valid this cycle.
REQ-013 Port: ld_ready  output  1  block accepts ld_data this cycle.
REQ-014 Port: busy  output  1  high in any state except RUN.

Function
REQ-015 States: HDR0, HDR1, HDR2, HDR3, DATA, HOLD, RUN.
REQ-016 A byte transfers only on a rising edge with ld_valid=1 and ld_ready=1.
REQ-017 ld_ready is 1 in HDR0..HDR3 and DATA and 0 otherwise; ld_valid gaps of any length stall without loss.
REQ-018 Header order: HDR0 start address low, HDR1 start address high, HDR2 count low, HDR3 count high; each transfer advances one state.
REQ-019 On HDR3 transfer: go to DATA if count != 0; go to HOLD if count == 0.
REQ-020 DATA: each transfer writes ld_data to mem[load_addr], increments load_addr modulo 2^AW (0xFFFF wraps to 0x0000), and decrements the count.
REQ-021 The transfer that brings the count to 0 moves the block to HOLD.
REQ-022 HOLD: cpu_reset=1 for exactly RST_HOLD cycles, then RUN.
REQ-023 RUN: cpu_reset=0; if we=1 at a rising edge, mem[ab] <= do.
REQ-024 The read address register captures ab on every rising edge in every state; di = mem[read address register], combinationally.
REQ-025 A write followed by a read of the same address on the next edge returns the new data (read-new-data).
REQ-026 In all states except RUN, cpu_reset=1 and CPU writes are ignored.
REQ-027 ld_start in RUN or HOLD moves the block to HDR0 on the next edge; cpu_reset is asserted from that edge.
REQ-028 ld_start in HDR0..DATA is ignored; the load in progress continues.
REQ-029 ld_valid is ignored when ld_ready=0.
REQ-030 Memory contents are not cleared by reset or ld_start.

Reset
REQ-031 While reset=0: state=HOLD, hold counter=0, cpu_reset=1, busy=1, ld_ready=0, load_addr=0, count=0, read address register=0.
REQ-032 After reset is released, the block stays in HOLD for RST_HOLD cycles, then enters RUN.
REQ-033 Reset asserted mid-load aborts the load; bytes already written remain in memory.

Verification
REQ-034 Load test: ld_start, then stream 00 13 03 00 AA BB CC -> mem[0x1300..0x1302] = AA BB CC; cpu_reset held 4 cycles after CC; then RUN; CPU read of 0x1301 gives di=BB one cycle later.
REQ-035 Wrap test: header FF FF 02 00, data 11 22 -> mem[0xFFFF]=11, mem[0x0000]=22.
REQ-036 Zero count: header 00 02 00 00 -> HOLD immediately after 4th byte; no memory change.
REQ-037 Backpressure: toggle ld_valid randomly during a 16-byte load -> all 16 bytes stored in order; ld_start pulsed mid-DATA is ignored.
REQ-038 CPU port: in RUN, we=1 ab=0x0055 do=0x43, next cycle ab=0x0055 we=0 -> di=0x43; the same write while busy=1 leaves mem[0x0055] unchanged.
REQ-039 Reset after the 2nd data byte of a 3-byte load -> cpu_reset=1 immediately; RUN after 4 cycles; first two bytes present, third location unchanged.

Source files
------------

// File: rtl/mem_loader_responder.sv
// Program memory for a 6502 core: a loader stream fills memory from a 4-byte header
// (start address, byte count) and holds the CPU in reset until the image is in place.
module mem_loader_responder #(
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned AW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ab,
  input  logic [7:0]    cpu_do,    // CPU write data ("do" is a reserved word)
  input  logic          we,
  output logic [7:0]    di,
  output logic          cpu_reset,
  input  logic          ld_start,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic          busy
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned HCW   = 8;
  localparam int unsigned CW    = 16;

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_HDR2 = 3'd2;
  localparam logic [2:0] S_HDR3 = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [2:0] S_RUN  = 3'd6;

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD - 1);

  logic [2:0]     state,     state_n;
  logic [HCW-1:0] hold_cnt,  hold_cnt_n;
  logic [AW-1:0]  load_addr, load_addr_n;
  logic [CW-1:0]  count,     count_n;
  logic [7:0]     addr_lo,   addr_lo_n;
  logic [AW-1:0]  rd_addr;
  logic           cpu_reset_n, busy_n, ld_ready_n;

  logic [7:0]     mem [DEPTH];

  logic           xfer;
  logic           ld_wr;
  logic           cpu_wr;
  logic [CW-1:0]  hdr_count;

  assign xfer      = ld_valid && ld_ready;
  assign ld_wr     = xfer && (state == S_DATA);
  assign cpu_wr    = we && (state == S_RUN);
  assign hdr_count = {ld_data, count[7:0]};

  // Next-state and datapath updates; outputs are decoded from the next state so they
  // land in flops alongside it.
  always_comb begin
    state_n     = state;
    hold_cnt_n  = hold_cnt;
    load_addr_n = load_addr;
    count_n     = count;
    addr_lo_n   = addr_lo;
    case (state)
      S_HDR0: if (xfer) begin
        addr_lo_n = ld_data;
        state_n   = S_HDR1;
      end
      S_HDR1: if (xfer) begin
        load_addr_n = AW'({ld_data, addr_lo});
        state_n     = S_HDR2;
      end
      S_HDR2: if (xfer) begin
        count_n = CW'(ld_data);
        state_n = S_HDR3;
      end
      S_HDR3: if (xfer) begin
        count_n = hdr_count;
        if (hdr_count == '0) begin
          state_n    = S_HOLD;
          hold_cnt_n = '0;
        end else begin
          state_n = S_DATA;
        end
      end
      S_DATA: if (xfer) begin
        load_addr_n = load_addr + AW'(1);
        count_n     = count - CW'(1);
        if (count == CW'(1)) begin
          state_n    = S_HOLD;
          hold_cnt_n = '0;
        end
      end
      S_HOLD: begin
        if (ld_start) begin
          state_n = S_HDR0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = S_RUN;
        end else begin
          hold_cnt_n = hold_cnt + HCW'(1);
        end
      end
      S_RUN: if (ld_start) state_n = S_HDR0;
      default: begin
        state_n    = S_HOLD;
        hold_cnt_n = '0;
      end
    endcase
    cpu_reset_n = (state_n != S_RUN);
    busy_n      = (state_n != S_RUN);
    ld_ready_n  = (state_n == S_HDR0) || (state_n == S_HDR1) || (state_n == S_HDR2) ||
                  (state_n == S_HDR3) || (state_n == S_DATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      load_addr <= '0;
      count     <= '0;
      addr_lo   <= '0;
      rd_addr   <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b1;
      ld_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      load_addr <= load_addr_n;
      count     <= count_n;
      addr_lo   <= addr_lo_n;
      rd_addr   <= ab;
      cpu_reset <= cpu_reset_n;
      busy      <= busy_n;
      ld_ready  <= ld_ready_n;
    end
  end

  // Memory survives reset; loader and CPU writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[load_addr] <= ld_data;
    end else if (cpu_wr) begin
      mem[ab] <= cpu_do;
    end
  end

  assign di = mem[rd_addr];

endmodule

// File: tb/tb_mem_loader_responder.sv
// Directed bench for mem_loader_responder: stimulus queues expected values with a due
// cycle, and a negedge monitor compares them against the DUT outputs.
module tb_mem_loader_responder;

  localparam int unsigned AW = 16;
  localparam int K_DI = 0, K_CPURST = 1, K_BUSY = 2, K_RDY = 3;

  logic          clk;
  logic          reset;
  logic [AW-1:0] ab;
  logic [7:0]    cpu_do;
  logic          we;
  logic [7:0]    di;
  logic          cpu_reset;
  logic          ld_start;
  logic [7:0]    ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          busy;

  mem_loader_responder #(.RST_HOLD(4), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di),
    .cpu_reset(cpu_reset), .ld_start(ld_start), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .busy(busy)
  );

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t       q[$];
  chk_t       mon_e;
  logic [7:0] mon_act;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         e;
  int         r;

  logic [7:0] bp [16] = '{8'h3C, 8'hA1, 8'h07, 8'hFE, 8'h5B, 8'h90, 8'h12, 8'hC4,
                          8'h6D, 8'h28, 8'hE3, 8'h71, 8'h0F, 8'hB6, 8'h49, 8'h84};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every entry whose cycle has come is compared against the selected output.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        K_DI:     mon_act = di;
        K_CPURST: mon_act = {7'b0, cpu_reset};
        K_BUSY:   mon_act = {7'b0, busy};
        K_RDY:    mon_act = {7'b0, ld_ready};
        default:  mon_act = 8'h00;
      endcase
      n_cmp++;
      if (mon_act !== mon_e.exp)begin
        n_err++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", mon_e.name, mon_act, mon_e.exp, cyc);
      end
    end
  end

  task automatic check_now(input logic [7:0] act, input logic [7:0] exp, input string name);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int due, input int kind, input logic [7:0] exp, input string name);
    chk_t c;
    c.due  = due;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    q.push_back(c);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    ab     = AW'(a);
    cpu_do = d;
    we     = 1'b1;
    @(negedge clk);
    we     = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    ab = AW'(a);
    we = 1'b0;
    expect_at(cyc + 1, K_DI, exp, name);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    logic done;
    n    = 0;
    done = 1'b0;
    ld_data  = b;
    ld_valid = 1'b1;
    while (!done && n < 32) begin
      rdy = ld_ready;
      @(negedge clk);
      n++;
      if (rdy) done = 1'b1;
    end
    ld_valid = 1'b0;
    check_now({7'b0, done}, 8'h01, "send_byte_timeout");
  endtask

  task automatic send_hdr(input logic [15:0] a, input logic [15:0] cnt);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_reset !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_now({7'b0, cpu_reset}, 8'h00, "wait_run_timeout");
  endtask

  initial begin
    reset = 1'b0; ab = '0; cpu_do = '0; we = 1'b0;
    ld_start = 1'b0; ld_data = '0; ld_valid = 1'b0;

    // Reset state and release timing
    @(negedge clk);
    check_now({7'b0, cpu_reset}, 8'h01, "rst_now_cpu_reset");
    check_now({7'b0, busy},      8'h01, "rst_now_busy");
    check_now({7'b0, ld_ready},  8'h00, "rst_now_ld_ready");
    expect_at(cyc + 1, K_CPURST, 8'h01, "rst_cpu_reset");
    expect_at(cyc + 1, K_BUSY,   8'h01, "rst_busy");
    expect_at(cyc + 1, K_RDY,    8'h00, "rst_ld_ready");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    r = cyc;
    expect_at(r + 3, K_CPURST, 8'h01, "rel_hold_last");
    expect_at(r + 4, K_CPURST, 8'h00, "rel_run_cpu_reset");
    expect_at(r + 4, K_BUSY,   8'h00, "rel_run_busy");
    expect_at(r + 4, K_RDY,    8'h00, "rel_run_ld_ready");
    wait_run();

    // CPU port read-new-data and background values
    cpu_write(16'h0055, 8'h43);
    cpu_read(16'h0055, 8'h43, "cpu_rd_new_data");
    cpu_write(16'h1303, 8'h5A);
    cpu_write(16'h0200, 8'h77);
    cpu_write(16'h3002, 8'hEE);
    cpu_write(16'h0001, 8'h33);

    // Basic load, with a CPU write attempted while busy
    expect_at(cyc + 1, K_CPURST, 8'h01, "start_cpu_reset");
    expect_at(cyc + 1, K_RDY,    8'h01, "start_ld_ready");
    pulse_start();
    expect_at(cyc + 1, K_BUSY, 8'h01, "load_busy");
    cpu_write(16'h0055, 8'h99);
    send_hdr(16'h1300, 16'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    e = cyc;
    expect_at(e + 1, K_CPURST, 8'h01, "load_hold1");
    expect_at(e + 1, K_RDY,    8'h00, "load_hold_rdy");
    expect_at(e + 2, K_CPURST, 8'h01, "load_hold2");
    expect_at(e + 3, K_CPURST, 8'h01, "load_hold3");
    expect_at(e + 4, K_CPURST, 8'h00, "load_run");
    wait_run();
    cpu_read(16'h1301, 8'hBB, "load_1301");
    cpu_read(16'h1300, 8'hAA, "load_1300");
    cpu_read(16'h1302, 8'hCC, "load_1302");
    cpu_read(16'h1303, 8'h5A, "load_1303_untouched");
    cpu_read(16'h0055, 8'h43, "busy_write_ignored");

    // Address wrap
    pulse_start();
    send_hdr(16'hFFFF, 16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_run();
    cpu_read(16'hFFFF, 8'h11, "wrap_ffff");
    cpu_read(16'h0000, 8'h22, "wrap_0000");
    cpu_read(16'h0001, 8'h33, "wrap_0001_untouched");

    // Zero-count header
    pulse_start();
    send_hdr(16'h0200, 16'd0);
    e = cyc;
    expect_at(e + 1, K_RDY,    8'h00, "zero_hold_rdy");
    expect_at(e + 3, K_CPURST, 8'h01, "zero_hold3");
    expect_at(e + 4, K_CPURST, 8'h00, "zero_run");
    wait_run();
    cpu_read(16'h0200, 8'h77, "zero_0200_untouched");

    // Backpressure with a stray ld_start mid-data
    pulse_start();
    send_hdr(16'h4000, 16'd16);
    for (int i = 0; i < 16; i++) begin
      ld_data = 8'hEE;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 8) pulse_start();
      send_byte(bp[i]);
    end
    wait_run();
    for (int i = 0; i < 16; i++) begin
      cpu_read(16'h4000 + 16'(i), bp[i], $sformatf("bp_%0d", i));
    end

    // Reset during a load
    pulse_start();
    send_hdr(16'h3000, 16'd3);
    send_byte(8'hD1);
    send_byte(8'hD2);
    @(posedge clk);
    #2 reset = 1'b0;
    expect_at(cyc, K_RDY,    8'h00, "abort_async_ld_ready");
    expect_at(cyc, K_CPURST, 8'h01, "abort_cpu_reset");
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    expect_at(r + 3, K_CPURST, 8'h01, "abort_hold3");
    expect_at(r + 4, K_CPURST, 8'h00, "abort_run");
    wait_run();
    cpu_read(16'h3000, 8'hD1, "abort_3000");
    cpu_read(16'h3001, 8'hD2, "abort_3001");
    cpu_read(16'h3002, 8'hEE, "abort_3002_untouched");

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
